match_round_controller: RTL and testbench

//   Sequences one rock-paper-scissors game between two players. Collects one move per player per

---
 rtl/match_round_controller.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_match_round_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_round_controller.sv
// ---------------------------------------------------------------------------
// match_round_controller
//
// Sequences one rock-paper-scissors game between two players. Each round
// collects exactly one move from each player, judges the pair, and updates
// the round / win / lose tallies. The game ends when either player reaches
// WIN_TARGET round wins or when the round count reaches MAX_ROUNDS.
//
// Move encoding   : 00 rock, 01 paper, 10 scissors, 11 invalid
// Result encoding : 00 none, 01 draw, 10 p1 wins, 11 p2 wins
//
// Handshake: a move transfers on a rising edge where pX_valid and pX_ready
// are both high. pX_ready is registered. It is high in COLLECT until that
// player's move has transferred, then low for the rest of the round, so at
// most one move per player is taken per round and later offers are ignored.
//
// Ports
//   clk          in   1  system clock, rising edge
//   resetn       in   1  synchronous reset, active-low
//   start        in   1  begin/restart a game (IDLE or GAME_OVER only)
//   p1_valid     in   1  player 1 move offered
//   p1_move      in   2  player 1 move
//   p1_ready     out  1  player 1 move accepted this cycle
//   p2_valid     in   1  player 2 move offered
//   p2_move      in   2  player 2 move
//   p2_ready     out  1  player 2 move accepted this cycle
//   result_valid out  1  one-cycle pulse when a round result is published
//   matchresult  out  2  last round result
//   round        out  4  rounds played this game
//   win          out  4  rounds won by player 1
//   lose         out  4  rounds won by player 2
//   game_over    out  1  high while in GAME_OVER
//   winner       out  2  overall game winner, valid while game_over
//   busy         out  1  high in COLLECT, JUDGE and UPDATE
//   state_dbg    out  3  current FSM state, for observation only
// ---------------------------------------------------------------------------
module match_round_controller #(
    parameter int WIN_TARGET     = 3,
    parameter int MAX_ROUNDS     = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    output logic       result_valid,
    output logic [1:0] matchresult,
    output logic [3:0] round,
    output logic [3:0] win,
    output logic [3:0] lose,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0]    WIN_LIMIT   = 4'(WIN_TARGET);
    localparam logic [3:0]    ROUND_LIMIT = 4'(MAX_ROUNDS);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] MV_ROCK     = 2'b00;
    localparam logic [1:0] MV_PAPER    = 2'b01;
    localparam logic [1:0] MV_SCISSORS = 2'b10;
    localparam logic [1:0] MV_INVALID  = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_DRAW = 2'b01;
    localparam logic [1:0] RES_P1   = 2'b10;
    localparam logic [1:0] RES_P2   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT   = 3'd1,
        S_JUDGE     = 3'd2,
        S_UPDATE    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Round judgement. An invalid move loses to any valid move; two invalid
    // moves are a draw. Otherwise paper>rock, scissors>paper, rock>scissors.
    function automatic logic [1:0] judge_moves(input logic [1:0] a,
                                               input logic [1:0] b);
        logic [1:0] r;
        r = RES_DRAW;
        if (a == MV_INVALID && b == MV_INVALID) begin
            r = RES_DRAW;
        end else if (a == MV_INVALID) begin
            r = RES_P2;
        end else if (b == MV_INVALID) begin
            r = RES_P1;
        end else if (a == b) begin
            r = RES_DRAW;
        end else if ((a == MV_PAPER    && b == MV_ROCK)  ||
                     (a == MV_SCISSORS && b == MV_PAPER) ||
                     (a == MV_ROCK     && b == MV_SCISSORS)) begin
            r = RES_P1;
        end else begin
            r = RES_P2;
        end
        return r;
    endfunction

    // Tally counters stop at 15 rather than wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t        state;
    logic [1:0]    mv1;
    logic [1:0]    mv2;
    logic [TW-1:0] timer;

    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Next-step decode
    // -----------------------------------------------------------------------
    logic          cap1;
    logic          cap2;
    logic          both_done;
    logic          one_held;
    logic [TW-1:0] timer_inc;
    logic          timeout_hit;
    logic          do_update;
    logic [1:0]    upd_result;
    logic          end_hit;
    logic [1:0]    final_winner;

    always_comb begin
        cap1         = 1'b0;
        cap2         = 1'b0;
        both_done    = 1'b0;
        one_held     = 1'b0;
        timer_inc    = timer + TW'(1);
        timeout_hit  = 1'b0;
        do_update    = 1'b0;
        upd_result   = RES_NONE;
        end_hit      = 1'b0;
        final_winner = RES_DRAW;

        if (state == S_COLLECT) begin
            cap1 = p1_valid && p1_ready;
            cap2 = p2_valid && p2_ready;
            // A player is done if captured earlier (ready already low) or now.
            both_done = (!p1_ready || cap1) && (!p2_ready || cap2);
            // Exactly one move already held going into this edge.
            one_held = (p1_ready != p2_ready);
            // A second capture on the same edge takes priority over forfeit.
            timeout_hit = one_held && !both_done && (timer_inc == TIMER_LIMIT);
        end

        do_update = (state == S_JUDGE) || timeout_hit;

        if (state == S_JUDGE) begin
            upd_result = judge_moves(mv1, mv2);
        end else if (timeout_hit) begin
            // The player whose ready is already low is the one who moved.
            upd_result = p1_ready ? RES_P2 : RES_P1;
        end

        // Tallies were updated on the edge into UPDATE, so these compare
        // against the post-increment values.
        end_hit = (win == WIN_LIMIT) || (lose == WIN_LIMIT) ||
                  (round == ROUND_LIMIT);

        if (win > lose) begin
            final_winner = RES_P1;
        end else if (lose > win) begin
            final_winner = RES_P2;
        end else begin
            final_winner = RES_DRAW;
        end
    end

    // -----------------------------------------------------------------------
    // FSM and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            mv1          <= MV_ROCK;
            mv2          <= MV_ROCK;
            timer        <= '0;
            p1_ready     <= 1'b0;
            p2_ready     <= 1'b0;
            result_valid <= 1'b0;
            matchresult  <= RES_NONE;
            round        <= 4'd0;
            win          <= 4'd0;
            lose         <= 4'd0;
            game_over    <= 1'b0;
            winner       <= RES_NONE;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;

            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        state       <= S_COLLECT;
                        round       <= 4'd0;
                        win         <= 4'd0;
                        lose        <= 4'd0;
                        matchresult <= RES_NONE;
                        winner      <= RES_NONE;
                        timer       <= '0;
                        game_over   <= 1'b0;
                        busy        <= 1'b1;
                        p1_ready    <= 1'b1;
                        p2_ready    <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (cap1) begin
                        mv1      <= p1_move;
                        p1_ready <= 1'b0;
                    end
                    if (cap2) begin
                        mv2      <= p2_move;
                        p2_ready <= 1'b0;
                    end
                    if (both_done) begin
                        state <= S_JUDGE;
                        timer <= '0;
                    end else if (timeout_hit) begin
                        // Forfeit: skip JUDGE, the result is published now.
                        state    <= S_UPDATE;
                        timer    <= '0;
                        p1_ready <= 1'b0;
                        p2_ready <= 1'b0;
                    end else if (one_held) begin
                        timer <= timer_inc;
                    end
                end

                S_JUDGE: begin
                    state <= S_UPDATE;
                end

                S_UPDATE: begin
                    if (end_hit) begin
                        state     <= S_GAME_OVER;
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                        winner    <= final_winner;
                    end else begin
                        state    <= S_COLLECT;
                        p1_ready <= 1'b1;
                        p2_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Publishing a result: shared by the judged path and the forfeit
            // path, both of which land in UPDATE on this edge.
            if (do_update) begin
                result_valid <= 1'b1;
                matchresult  <= upd_result;
                round        <= sat_inc(round);
                if (upd_result == RES_P1) begin
                    win <= sat_inc(win);
                end
                if (upd_result == RES_P2) begin
                    lose <= sat_inc(lose);
                end
            end
        end
    end

endmodule

// File: tb/tb_match_round_controller.sv
// Bench for match_round_controller: reset checks, a table of hand-chosen
// rounds across several games, randomized rounds, reset in JUDGE, and an
// idle COLLECT window with no moves.
module tb_match_round_controller;

  localparam int WIN_TARGET     = 3;
  localparam int MAX_ROUNDS     = 5;
  localparam int TIMEOUT_CYCLES = 4;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_move  = 2'b00;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_move  = 2'b00;
  logic       p1_ready;
  logic       p2_ready;
  logic       result_valid;
  logic [1:0] matchresult;
  logic [3:0] round;
  logic [3:0] win;
  logic [3:0] lose;
  logic       game_over;
  logic [1:0] winner;
  logic       busy;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  match_round_controller #(
    .WIN_TARGET    (WIN_TARGET),
    .MAX_ROUNDS    (MAX_ROUNDS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .p1_valid    (p1_valid),
    .p1_move     (p1_move),
    .p1_ready    (p1_ready),
    .p2_valid    (p2_valid),
    .p2_move     (p2_move),
    .p2_ready    (p2_ready),
    .result_valid(result_valid),
    .matchresult (matchresult),
    .round       (round),
    .win         (win),
    .lose        (lose),
    .game_over   (game_over),
    .winner      (winner),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [13:0] exp_q[$];   // {matchresult, round, win, lose}
  int m_round = 0;
  int m_win   = 0;
  int m_lose  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Game rules stated directly: difference mod 3 decides the round.
  function automatic int ref_judge(input int a, input int b);
    int d;
    if (a == 3 && b == 3) return 1;
    if (a == 3) return 3;
    if (b == 3) return 2;
    d = ((a - b) % 3 + 3) % 3;
    if (d == 0) return 1;
    if (d == 1) return 2;
    return 3;
  endfunction

  function automatic bit model_over();
    return (m_win == WIN_TARGET) || (m_lose == WIN_TARGET) || (m_round == MAX_ROUNDS);
  endfunction

  function automatic int model_winner();
    if (m_win > m_lose) return 2;
    if (m_lose > m_win) return 3;
    return 1;
  endfunction

  task automatic model_apply(input int res);
    logic [13:0] e;
    if (m_round < 15) m_round++;
    if (res == 2 && m_win < 15) m_win++;
    if (res == 3 && m_lose < 15) m_lose++;
    e = {2'(res), 4'(m_round), 4'(m_win), 4'(m_lose)};
    exp_q.push_back(e);
  endtask

  // Every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    logic [13:0] e;
    if (result_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_result: got result_valid with mr=%0d round=%0d, expected no pulse",
                 matchresult, round);
      end else begin
        e = exp_q.pop_front();
        if ({matchresult, round, win, lose} !== e) begin
          n_errors++;
          $display("FAIL result_tally: got mr=%0d r=%0d w=%0d l=%0d, expected mr=%0d r=%0d w=%0d l=%0d",
                   matchresult, round, win, lose, e[13:12], e[11:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic check_all_zero(input string tag);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_matchresult"}, matchresult, 0);
    check({tag, "_round"}, round, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_lose"}, lose, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_winner"}, winner, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_p1_ready"}, p1_ready, 0);
    check({tag, "_p2_ready"}, p2_ready, 0);
  endtask

  task automatic begin_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_round = 0;
    m_win   = 0;
    m_lose  = 0;
    check("start_round", round, 0);
    check("start_win", win, 0);
    check("start_lose", lose, 0);
    check("start_matchresult", matchresult, 0);
    check("start_winner", winner, 0);
    check("start_game_over", game_over, 0);
    check("start_busy", busy, 1);
    check("start_ready", {p1_ready, p2_ready}, 2'b11);
  endtask

  // dX: negedge index at which player X starts offering (-1 = never).
  // noisy: hold start high and keep re-offering a different move after
  // capture; both must be ignored.
  task automatic play_round(input int m1, input int d1, input int m2, input int d2,
                            input bit noisy, input int exp_res);
    int c1;
    int c2;
    int got_c;
    int last;
    int exp_lat;
    bit forfeit;
    c1 = -1;
    c2 = -1;
    got_c = -1;
    forfeit = (d1 < 0) || (d2 < 0);
    model_apply(exp_res);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) begin
        got_c = c;
        break;
      end
      p1_valid = 1'b0;
      p2_valid = 1'b0;
      start    = noisy;
      if (d1 >= 0 && c >= d1) begin
        if (c1 < 0) begin
          p1_valid = 1'b1;
          p1_move  = 2'(m1);
          if (p1_ready) c1 = c;
        end else if (noisy) begin
          check("reoffer_p1_ready", p1_ready, 0);
          p1_valid = 1'b1;
          p1_move  = 2'(m1) ^ 2'b11;
        end
      end
      if (d2 >= 0 && c >= d2) begin
        if (c2 < 0) begin
          p2_valid = 1'b1;
          p2_move  = 2'(m2);
          if (p2_ready) c2 = c;
        end else if (noisy) begin
          check("reoffer_p2_ready", p2_ready, 0);
          p2_valid = 1'b1;
          p2_move  = 2'(m2) ^ 2'b11;
        end
      end
    end
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    start    = 1'b0;
    if (got_c < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL round_timeout: got no result_valid in 40 cycles, expected mr=%0d", exp_res);
    end else begin
      if (forfeit) begin
        last    = (c1 >= 0) ? c1 : c2;
        exp_lat = TIMEOUT_CYCLES + 1;
      end else begin
        last    = (c1 > c2) ? c1 : c2;
        exp_lat = 2;
      end
      check("latency", got_c - last, exp_lat);
    end
    // One cycle after the pulse: pulse gone, game either continues or ended.
    @(negedge clk);
    check("pulse_width", result_valid, 0);
    check("after_round", round, m_round);
    check("after_win", win, m_win);
    check("after_lose", lose, m_lose);
    check("after_game_over", game_over, model_over());
    check("after_winner", winner, model_over() ? model_winner() : 0);
    check("after_busy", busy, !model_over());
    check("after_p1_ready", p1_ready, !model_over());
  endtask

  // ---------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------
  typedef struct {
    bit new_game;
    int m1;
    int m2;
    int d1;
    int d2;
    bit noisy;
    int exp_res;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int pulses;
    int m1;
    int m2;
    int d1;
    int d2;
    int res;
    bit noisy;

    //            new m1 m2 d1  d2 noisy res
    vecs[0]  = '{1, 1, 0,  0,  0, 0, 2};   // paper beats rock
    vecs[1]  = '{0, 2, 2,  0,  3, 1, 1};   // staggered, re-offer ignored, draw
    vecs[2]  = '{0, 3, 0,  1,  0, 0, 3};   // invalid loses to rock
    vecs[3]  = '{0, 3, 3,  2,  2, 0, 1};   // both invalid: draw
    vecs[4]  = '{0, 0, 2,  0,  1, 0, 2};   // round limit reached
    vecs[5]  = '{1, 0, 1,  0,  0, 0, 3};   // p2 three straight
    vecs[6]  = '{0, 1, 2,  3,  0, 0, 3};
    vecs[7]  = '{0, 2, 0,  0,  2, 0, 3};   // lose hits win target
    vecs[8]  = '{1, 1, 0,  0, -1, 0, 2};   // p1 wins by forfeit
    vecs[9]  = '{0, 0, 2, -1,  1, 0, 3};   // p2 wins by forfeit
    vecs[10] = '{0, 2, 1,  2,  2, 0, 2};
    vecs[11] = '{0, 1, 1,  0,  0, 0, 1};
    vecs[12] = '{0, 0, 0,  1,  3, 0, 1};
    vecs[13] = '{1, 0, 0,  0,  0, 0, 1};   // five draws: overall draw
    vecs[14] = '{0, 1, 1,  1,  0, 0, 1};
    vecs[15] = '{0, 2, 2,  0,  2, 0, 1};
    vecs[16] = '{0, 3, 3,  0,  0, 0, 1};
    vecs[17] = '{0, 1, 1,  3,  1, 0, 1};

    // Reset behaviour
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].new_game) begin_game();
      play_round(vecs[i].m1, vecs[i].d1, vecs[i].m2, vecs[i].d2, vecs[i].noisy, vecs[i].exp_res);
    end

    // Randomized rounds against the model
    for (int n = 0; n < 60; n++) begin
      if (model_over()) begin_game();
      m1 = $urandom_range(0, 3);
      m2 = $urandom_range(0, 3);
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      noisy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) d1 = -1;
        else d2 = -1;
      end
      if (d1 < 0) res = 3;
      else if (d2 < 0) res = 2;
      else res = ref_judge(m1, m2);
      play_round(m1, d1, m2, d2, noisy, res);
    end

    // Reset while in JUDGE with both moves captured
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    begin_game();
    play_round(0, 0, 2, 0, 0, 2);
    check("mid_ready_before", {p1_ready, p2_ready}, 2'b11);
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    p2_valid = 1'b1;
    p2_move  = 2'b00;
    @(negedge clk);
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    check("mid_judge_busy", busy, 1);
    check("mid_judge_ready", {p1_ready, p2_ready}, 2'b00);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_round = 0;
    m_win   = 0;
    m_lose  = 0;
    check_all_zero("mid_reset");
    repeat (5) @(negedge clk);
    check_all_zero("mid_reset_idle");

    // No moves at all: no result for 100 cycles
    begin_game();
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_round", round, 0);
    check("idle_busy", busy, 1);
    check("idle_ready", {p1_ready, p2_ready}, 2'b11);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
